// File: rtl/camera_capture_ctrl_pkg.sv
// cam_pkg: shared capture-pipeline state type and default frame geometry.
package cam_pkg;
    localparam int DEF_FRAME_PIXELS = 76800;
    localparam int DEF_ADDR_W = 17;
    typedef enum logic [2:0] {CONFIG, SETTLE, IDLE, ARMED, CAPTURE, ERROR} cam_state_t;
endpackage

// File: rtl/camera_capture_ctrl_if.sv
// camera_capture_ctrl_if: sensor, pixel-stream and frame-buffer signals of the capture sequencer.
interface camera_capture_ctrl_if import cam_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W
);
    logic cap_req, cap_continuous, sccb_done, pix_valid, frame_done;
    logic [7:0] pix_data;
    logic cam_start, fb_we, busy, cfg_ok, frame_ready, err_short, err_long, err_timeout;
    logic [ADDR_W-1:0] fb_addr;
    logic [7:0] fb_data;
    modport slave (
        input  cap_req, cap_continuous, sccb_done, pix_valid, pix_data, frame_done,
        output cam_start, fb_we, fb_addr, fb_data, busy, cfg_ok, frame_ready,
               err_short, err_long, err_timeout
    );
    modport master (
        output cap_req, cap_continuous, sccb_done, pix_valid, pix_data, frame_done,
        input  cam_start, fb_we, fb_addr, fb_data, busy, cfg_ok, frame_ready,
               err_short, err_long, err_timeout
    );
endinterface

// File: rtl/camera_capture_ctrl_fb_writer.sv
// cam_fb_writer: pixel counter, registered frame-buffer write port and frame length checking.
module cam_fb_writer import cam_pkg::*; #(
    parameter int FRAME_PIXELS = DEF_FRAME_PIXELS,
    parameter int ADDR_W       = DEF_ADDR_W
) (
    input  logic              clk25,
    input  logic              rst,
    input  logic              i_en,
    input  logic              i_err_clr,
    input  logic              i_pix_valid,
    input  logic [7:0]        i_pix_data,
    input  logic              i_frame_done,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_addr,
    output logic [7:0]        o_data,
    output logic              o_ready,
    output logic              o_err_short,
    output logic              o_err_long
);
    localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(FRAME_PIXELS);
    logic [ADDR_W:0] r_cnt, w_cnt_nx;
    logic r_ovf, w_take, w_over, w_ovf_nx, w_end;
    // A pixel coincident with frame_done is counted before the length check.
    always_comb begin
        w_take   = i_en && i_pix_valid && r_cnt < FULL;
        w_over   = i_en && i_pix_valid && r_cnt == FULL;
        w_end    = i_en && i_frame_done;
        w_cnt_nx = r_cnt + (ADDR_W + 1)'(w_take);
        w_ovf_nx = r_ovf || w_over;
    end
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            o_we        <= 1'b0;
            o_addr      <= '0;
            o_data      <= '0;
            o_ready     <= 1'b0;
            o_err_short <= 1'b0;
            o_err_long  <= 1'b0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
        end else begin
            o_we        <= w_take;
            o_addr      <= w_take ? r_cnt[ADDR_W-1:0] : o_addr;
            o_data      <= w_take ? i_pix_data : o_data;
            o_ready     <= w_end && w_cnt_nx == FULL && !w_ovf_nx;
            o_err_short <= !i_err_clr && (o_err_short || (w_end && w_cnt_nx < FULL));
            o_err_long  <= !i_err_clr && (o_err_long || w_over);
            r_cnt       <= (!i_en || i_frame_done) ? '0 : w_cnt_nx;
            r_ovf       <= i_en && !i_frame_done && w_ovf_nx;
        end
    end
endmodule

// File: rtl/camera_capture_ctrl.sv
// camera_capture_ctrl: sensor bring-up, settle-frame skipping and single/continuous frame capture sequencing.
module camera_capture_ctrl import cam_pkg::*; #(
    parameter int FRAME_PIXELS = DEF_FRAME_PIXELS,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int SKIP_FRAMES  = 2,
    parameter int CFG_TIMEOUT  = 1048576
) (
    input logic                  clk25,
    input logic                  rst,
    camera_capture_ctrl_if.slave cam
);
    localparam int TMO_W = $clog2(CFG_TIMEOUT + 1);
    localparam int SKP_W = $clog2(SKIP_FRAMES + 2);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(CFG_TIMEOUT - 1);
    localparam logic [SKP_W-1:0] SKP_LAST = SKP_W'(SKIP_FRAMES > 0 ? SKIP_FRAMES - 1 : 0);
    cam_state_t r_state, w_next;
    logic [TMO_W-1:0] r_tmo;
    logic [SKP_W-1:0] r_skip;
    logic r_cam_start, w_accept, w_settled;
    always_comb begin
        w_next    = r_state;
        w_settled = SKIP_FRAMES == 0 || (cam.frame_done && r_skip == SKP_LAST);
        w_accept  = r_state == IDLE && cam.cap_req;
        case (r_state)
            CONFIG:  w_next = cam.sccb_done ? SETTLE : (r_tmo == TMO_LAST ? ERROR : CONFIG);
            SETTLE:  w_next = w_settled ? IDLE : SETTLE;
            IDLE:    w_next = cam.cap_req ? ARMED : IDLE;
            ARMED:   w_next = cam.frame_done ? CAPTURE : ARMED;
            CAPTURE: w_next = (cam.frame_done && !cam.cap_continuous) ? IDLE : CAPTURE;
            default: w_next = ERROR;
        endcase
    end
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            r_state     <= CONFIG;
            r_tmo       <= '0;
            r_skip      <= '0;
            r_cam_start <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_tmo       <= r_state == CONFIG ? r_tmo + TMO_W'(1) : '0;
            r_skip      <= r_state == SETTLE ? r_skip + SKP_W'(cam.frame_done) : '0;
            r_cam_start <= w_next != ERROR;
        end
    end
    assign cam.cam_start   = r_cam_start;
    assign cam.busy        = r_state inside {ARMED, CAPTURE};
    assign cam.cfg_ok      = r_state inside {IDLE, ARMED, CAPTURE};
    assign cam.err_timeout = r_state == ERROR;
    cam_fb_writer #(.FRAME_PIXELS(FRAME_PIXELS), .ADDR_W(ADDR_W)) u_writer (
        .clk25       (clk25),
        .rst         (rst),
        .i_en        (r_state == CAPTURE),
        .i_err_clr   (w_accept),
        .i_pix_valid (cam.pix_valid),
        .i_pix_data  (cam.pix_data),
        .i_frame_done(cam.frame_done),
        .o_we        (cam.fb_we),
        .o_addr      (cam.fb_addr),
        .o_data      (cam.fb_data),
        .o_ready     (cam.frame_ready),
        .o_err_short (cam.err_short),
        .o_err_long  (cam.err_long)
    );
endmodule

// File: doc/camera_capture_ctrl.md
Name: camera_capture_ctrl

Overview:
Frame-capture sequencer for the camera pipeline, clocked on clk25. Sequencing:
- Brings the sensor up by driving the start line into the SCCB configurator and waiting for its done flag.
- Discards settling frames.
- On request, gates exactly one frame (or continuous frames) of grayscale pixels into the frame buffer with sequential write addresses.
- Checks every captured frame for correct pixel count.

Pixel strobe and frame-done inputs arrive already synchronous to clk25, via the upstream CDC FIFO.

Parameters:
- FRAME_PIXELS, 76800, pixels per captured frame (320x240 gray).
- ADDR_W, 17, frame-buffer address width; must satisfy 2^ADDR_W >= FRAME_PIXELS.
- SKIP_FRAMES, 2, frame_done pulses discarded after configuration completes.
- CFG_TIMEOUT, 1048576, clk25 cycles allowed for sccb_done before error.

Ports:
- clk25  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- cap_req  in  1  single-cycle capture request.
- cap_continuous  in  1  when high, capture back-to-back frames until dropped.
- sccb_done  in  1  level from SCCB configurator, high once register load is finished.
- pix_valid  in  1  one-cycle gray pixel strobe.
- pix_data  in  8  gray pixel value.
- frame_done  in  1  one-cycle end-of-frame pulse.
- cam_start  out  1  drives configurator start and xclk gating.
- fb_we  out  1  frame-buffer write enable.
- fb_addr  out  ADDR_W  frame-buffer write address.
- fb_data  out  8  frame-buffer write data.
- busy  out  1  high in ARMED or CAPTURE.
- cfg_ok  out  1  high once sensor is configured and settled.
- frame_ready  out  1  one-cycle pulse: good frame stored.
- err_short  out  1  sticky: frame ended with fewer than FRAME_PIXELS pixels.
- err_long  out  1  sticky: more than FRAME_PIXELS pixels seen; extras dropped.
- err_timeout  out  1  sticky: sccb_done not seen within CFG_TIMEOUT.

Behaviour:
- Reset (async, rst=1):
  - State is CONFIG.
  - All outputs are 0.
  - Timeout, skip and pixel counters are cleared.
- States and transitions:
  - CONFIG: cam_start=1 from the first cycle after reset release and held high in every later state except ERROR. Timeout counter increments each cycle.
    - sccb_done=1 -> SETTLE.
    - Counter reaches CFG_TIMEOUT-1 without sccb_done -> ERROR.
  - SETTLE: count frame_done pulses. After the SKIP_FRAMES-th pulse -> IDLE and cfg_ok=1 (held until reset). With SKIP_FRAMES=0, go straight to IDLE.
  - IDLE: cap_req -> ARMED. Accepting cap_req clears err_short and err_long.
  - ARMED: wait for frame_done, which marks the start of the next full frame. On frame_done -> CAPTURE with pixel count = 0. pix_valid in ARMED is ignored.
  - CAPTURE: each pix_valid with count < FRAME_PIXELS:
    - Next cycle: fb_we=1, fb_addr=count, fb_data=pix_data. Latency is exactly 1 cycle, all registered.
    - Then count increments.
  - CAPTURE: pix_valid with count == FRAME_PIXELS -> no write, err_long set.
  - CAPTURE, on frame_done:
    - count == FRAME_PIXELS and no overflow this frame -> frame_ready pulses the next cycle.
    - count < FRAME_PIXELS -> err_short set, no frame_ready.
    - Then count resets to 0. cap_continuous high -> stay in CAPTURE; low -> IDLE.
  - ERROR: cam_start=0 and err_timeout=1. Only rst exits.
- Simultaneous pix_valid and frame_done in CAPTURE: the pixel belongs to the ending frame. It is written and counted before the count check.
- cap_req while busy, in CONFIG, or in SETTLE: ignored, not queued.
- cap_continuous dropped mid-frame: the current frame completes normally, then IDLE.
- fb_we is never high outside the cycle after an accepted CAPTURE pixel.
- Reset mid-capture: immediate return to CONFIG. Partial frame is abandoned, no frame_ready; the sensor is reconfigured.
- Pixel counter width is ADDR_W+1, so it never wraps.

Decomposition:
- Shared package cam_pkg:
  - State enum: CONFIG, SETTLE, IDLE, ARMED, CAPTURE, ERROR.
  - Default FRAME_PIXELS and ADDR_W constants, reused by the frame buffer and VGA readout.
- One sub-module: cam_fb_writer. Holds the pixel counter, the registered write port, and overflow/short detection. The top FSM drives its clear and enable inputs.

Test Plan:
- Reset release, sccb_done high at cycle 100, two frame_done pulses -> cam_start=1 at cycle 1, cfg_ok=1 one cycle after the 2nd pulse, no fb_we.
- sccb_done held low, CFG_TIMEOUT=64 -> err_timeout=1 and cam_start=0 at cycle 64; cap_req ignored afterwards.
- FRAME_PIXELS=16, cap_req, frame_done, 16 pixels 0x10..0x1F, frame_done -> fb_addr 0..15 with matching data, 1 cycle after each strobe; one frame_ready; back to IDLE.
- Same setup, 12 pixels, then frame_done -> err_short=1, no frame_ready. Then 20 pixels -> 16 writes, err_long=1. Next cap_req clears both flags.
- cap_continuous=1 for 3 frames, last pixel coincident with frame_done -> 3 frame_ready pulses; fb_addr restarts at 0 each frame; the coincident pixel is written at addr 15.
- rst asserted at pixel 8 of a capture -> all outputs 0 immediately; after release, full CONFIG/SETTLE sequence repeats before cfg_ok.
